// File: rtl/rv_decode_stage.sv
// RV32/RV64 I(+M) decode stage: one decoded record per instruction, latency 1, via a 2-entry buffer.
// Backpressure: in_ready (registered) drops once two records are held; out_ready pops the head.
module rv_decode_stage #(
  parameter int XLEN  = 64,
  parameter bit EN_M  = 1'b1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [3:0]       out_class,
  output logic [4:0]       out_alu_op,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic             out_we_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic             out_illegal,
  output logic             out_halt,
  output logic [CNT_W-1:0] out_count
);

  localparam logic [3:0] C_OP     = 4'd0;
  localparam logic [3:0] C_OPIMM  = 4'd1;
  localparam logic [3:0] C_LOAD   = 4'd2;
  localparam logic [3:0] C_STORE  = 4'd3;
  localparam logic [3:0] C_BRANCH = 4'd4;
  localparam logic [3:0] C_LUI    = 4'd5;
  localparam logic [3:0] C_AUIPC  = 4'd6;
  localparam logic [3:0] C_JAL    = 4'd7;
  localparam logic [3:0] C_JALR   = 4'd8;
  localparam logic [3:0] C_OP32   = 4'd9;
  localparam logic [3:0] C_OPIMM32= 4'd10;
  localparam logic [3:0] C_SYSTEM = 4'd11;
  localparam logic [3:0] C_ILL    = 4'd15;

  localparam bit RV64 = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [3:0]      cls;
    logic [4:0]      alu_op;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            we_rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            illegal;
    logic            halt;
  } rec_t;

  rec_t             dec;
  rec_t             head_q, head_d;
  rec_t             skid_q, skid_d;
  logic [1:0]       occ_q, occ_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] i;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [5:0]  f6;
  logic        shift_f6_ok;
  logic        legal;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign i  = in_instr;
  assign f3 = i[14:12];
  assign f7 = i[31:25];
  assign f6 = i[31:26];
  // slli/srli need funct6 zero; srai additionally allows 010000
  assign shift_f6_ok = (f6 == 6'b000000) || ((f3 == 3'b101) && (f6 == 6'b010000));

  assign imm_i  = XLEN'($signed(i[31:20]));
  assign imm_s  = XLEN'($signed({i[31:25], i[11:7]}));
  assign imm_b  = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({i[31:12], 12'h000}));
  assign imm_j  = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
  assign imm_sh = XLEN'(i[25:20]);

  always_comb begin
    dec        = '0;
    dec.pc     = in_pc;
    dec.cls    = C_ILL;
    legal      = 1'b0;
    case (i[6:0])
      7'b0110011: begin
        dec.cls = C_OP;
        dec.rd = i[11:7]; dec.rs1 = i[19:15]; dec.rs2 = i[24:20];
        dec.alu_op = {i[30], i[25], f3};
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                ((f7 == 7'b0000001) && EN_M);
      end
      7'b0111011: begin
        dec.cls = C_OP32;
        dec.rd = i[11:7]; dec.rs1 = i[19:15]; dec.rs2 = i[24:20];
        dec.alu_op = {i[30], i[25], f3};
        legal = RV64 && ((f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                ((f7 == 7'b0000001) && EN_M && (f3 != 3'b001) && (f3 != 3'b010) && (f3 != 3'b011)));
      end
      7'b0010011: begin
        dec.cls = C_OPIMM;
        dec.rd = i[11:7]; dec.rs1 = i[19:15];
        dec.alu_op = {i[30] & (f3 == 3'b101), 1'b0, f3};
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          dec.imm = imm_sh;
          legal   = shift_f6_ok && (RV64 || !i[25]);
        end else begin
          dec.imm = imm_i;
          legal   = 1'b1;
        end
      end
      7'b0011011: begin
        dec.cls = C_OPIMM32;
        dec.rd = i[11:7]; dec.rs1 = i[19:15];
        dec.alu_op = {i[30] & (f3 == 3'b101), 1'b0, f3};
        if (f3 == 3'b000) begin
          dec.imm = imm_i;
          legal   = RV64;
        end else if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          dec.imm = imm_sh;
          legal   = RV64 && !i[25] && shift_f6_ok;
        end
      end
      7'b0000011: begin
        dec.cls = C_LOAD;
        dec.rd = i[11:7]; dec.rs1 = i[19:15]; dec.imm = imm_i;
        dec.alu_op = {2'b00, f3};
        legal = (f3 != 3'b111) && (RV64 || ((f3 != 3'b011) && (f3 != 3'b110)));
      end
      7'b0100011: begin
        dec.cls = C_STORE;
        dec.rs1 = i[19:15]; dec.rs2 = i[24:20]; dec.imm = imm_s;
        dec.alu_op = {2'b00, f3};
        legal = !f3[2] && (RV64 || (f3 != 3'b011));
      end
      7'b1100011: begin
        dec.cls = C_BRANCH;
        dec.rs1 = i[19:15]; dec.rs2 = i[24:20]; dec.imm = imm_b;
        dec.alu_op = {2'b00, f3};
        legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      7'b0110111: begin
        dec.cls = C_LUI; dec.rd = i[11:7]; dec.imm = imm_u; legal = 1'b1;
      end
      7'b0010111: begin
        dec.cls = C_AUIPC; dec.rd = i[11:7]; dec.imm = imm_u; legal = 1'b1;
      end
      7'b1101111: begin
        dec.cls = C_JAL; dec.rd = i[11:7]; dec.imm = imm_j; legal = 1'b1;
      end
      7'b1100111: begin
        dec.cls = C_JALR; dec.rd = i[11:7]; dec.rs1 = i[19:15]; dec.imm = imm_i;
        dec.alu_op = {2'b00, f3};
        legal = 1'b1;
      end
      7'b1110011: begin
        dec.cls = C_SYSTEM; dec.rd = i[11:7]; dec.rs1 = i[19:15]; dec.imm = imm_i;
        dec.alu_op = {2'b00, f3};
        legal = ((f3 != 3'b000) && (f3[2] == 1'b0)) ||
                (i == 32'h0000_0073) || (i == 32'h0010_0073);
      end
      default: legal = 1'b0;
    endcase

    // All-zero word is a stop request, not an illegal instruction
    if (i == 32'h0) begin
      dec.halt    = 1'b1;
      dec.illegal = 1'b0;
      dec.cls     = C_ILL;
    end else if (!legal) begin
      dec.illegal = 1'b1;
      dec.cls     = C_ILL;
    end
    dec.we_rd  = (dec.rd != 5'd0) && !dec.illegal && !dec.halt &&
                 (dec.cls != C_STORE) && (dec.cls != C_BRANCH) && (dec.cls != C_ILL);
    dec.target = ((dec.cls == C_BRANCH) || (dec.cls == C_JAL)) ? (in_pc + dec.imm) : '0;
  end

  logic push, pop;
  assign push = in_valid && in_ready_q && !flush;
  assign pop  = (occ_q != 2'd0) && out_ready && !flush;

  always_comb begin
    head_d  = head_q;
    skid_d  = skid_q;
    occ_d   = occ_q;
    count_d = count_q;
    if (flush) begin
      occ_d = 2'd0;
    end else begin
      if (pop) count_d = count_q + 1'b1;
      case (occ_q)
        2'd0: if (push) begin head_d = dec; occ_d = 2'd1; end
        2'd1: begin
          if (pop && push) head_d = dec;
          else if (pop)    occ_d = 2'd0;
          else if (push) begin skid_d = dec; occ_d = 2'd2; end
        end
        default: if (pop) begin head_d = skid_q; occ_d = 2'd1; end
      endcase
    end
    in_ready_d = (occ_d != 2'd2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      skid_q     <= '0;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b0;
      count_q    <= '0;
    end else begin
      head_q     <= head_d;
      skid_q     <= skid_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      count_q    <= count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (occ_q != 2'd0);
  assign out_pc      = head_q.pc;
  assign out_class   = head_q.cls;
  assign out_alu_op  = head_q.alu_op;
  assign out_rd      = head_q.rd;
  assign out_rs1     = head_q.rs1;
  assign out_rs2     = head_q.rs2;
  assign out_we_rd   = head_q.we_rd;
  assign out_imm     = head_q.imm;
  assign out_target  = head_q.target;
  assign out_illegal = head_q.illegal;
  assign out_halt    = head_q.halt;
  assign out_count   = count_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed checks of rv_decode_stage: RV64+M instance (a) alongside an RV32, no-M instance (b).
module tb_rv_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        a_in_ready, a_out_valid, a_we_rd, a_illegal, a_halt;
  logic [63:0] a_pc, a_imm, a_target;
  logic [3:0]  a_class;
  logic [4:0]  a_alu_op, a_rd, a_rs1, a_rs2;
  logic [31:0] a_count;

  logic        b_in_ready, b_out_valid, b_we_rd, b_illegal, b_halt;
  logic [31:0] b_pc, b_imm, b_target;
  logic [3:0]  b_class;
  logic [4:0]  b_alu_op, b_rd, b_rs1, b_rs2;
  logic [31:0] b_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rv_decode_stage #(.XLEN(64), .EN_M(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_class(a_class), .out_alu_op(a_alu_op), .out_rd(a_rd),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_we_rd(a_we_rd), .out_imm(a_imm),
    .out_target(a_target), .out_illegal(a_illegal), .out_halt(a_halt), .out_count(a_count)
  );

  rv_decode_stage #(.XLEN(32), .EN_M(1'b0), .CNT_W(32)) dut_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_class(b_class), .out_alu_op(b_alu_op), .out_rd(b_rd),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_we_rd(b_we_rd), .out_imm(b_imm),
    .out_target(b_target), .out_illegal(b_illegal), .out_halt(b_halt), .out_count(b_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the record is captured at the next posedge and visible at the following negedge.
  task automatic push1(input logic [31:0] ins, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 64'h0;
    repeat (2) @(negedge clk);
    check("rst_in_ready",  {63'd0, a_in_ready},  64'd0);
    check("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst_count",     {32'd0, a_count},     64'd0);
    check("rst_pc",        a_pc,                 64'd0);
    check("rst_b_in_ready",{63'd0, b_in_ready},  64'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rel_in_ready",  {63'd0, a_in_ready},  64'd1);
    check("rel_out_valid", {63'd0, a_out_valid}, 64'd0);

    // add x1,x2,x3
    push1(32'h003100B3, 64'h1000);
    check("add_valid", {63'd0, a_out_valid}, 64'd1);
    check("add_class", {60'd0, a_class}, 64'd0);
    check("add_rd",    {59'd0, a_rd},    64'd1);
    check("add_rs1",   {59'd0, a_rs1},   64'd2);
    check("add_rs2",   {59'd0, a_rs2},   64'd3);
    check("add_alu",   {59'd0, a_alu_op},64'd0);
    check("add_we",    {63'd0, a_we_rd}, 64'd1);
    check("add_ill",   {63'd0, a_illegal},64'd0);
    check("add_pc",    a_pc, 64'h1000);
    check("b_add_class", {60'd0, b_class}, 64'd0);

    // beq x0,x0,-4
    push1(32'hFE000EE3, 64'h1000);
    check("beq_class",  {60'd0, a_class}, 64'd4);
    check("beq_imm",    a_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("beq_target", a_target, 64'h0FFC);
    check("beq_we",     {63'd0, a_we_rd}, 64'd0);
    check("b_beq_imm",  {32'd0, b_imm}, 64'h0000_0000_FFFF_FFFC);
    check("b_beq_target", {32'd0, b_target}, 64'h0FFC);

    // srai x5,x6,63
    push1(32'h43F35293, 64'h1004);
    check("srai_class", {60'd0, a_class}, 64'd1);
    check("srai_imm",   a_imm, 64'd63);
    check("srai_alu",   {59'd0, a_alu_op}, 64'b10101);
    check("srai_rd",    {59'd0, a_rd}, 64'd5);
    check("srai_rs1",   {59'd0, a_rs1}, 64'd6);
    check("b_srai_ill", {63'd0, b_illegal}, 64'd1);
    check("b_srai_class", {60'd0, b_class}, 64'd15);
    check("b_srai_we",  {63'd0, b_we_rd}, 64'd0);

    // mul x0,x1,x2
    push1(32'h02208033, 64'h1008);
    check("mul_alu",   {59'd0, a_alu_op}, 64'b01000);
    check("mul_we",    {63'd0, a_we_rd}, 64'd0);
    check("mul_ill",   {63'd0, a_illegal}, 64'd0);
    check("b_mul_ill", {63'd0, b_illegal}, 64'd1);

    // lui x7,0x80000: sign extension of bit 31
    push1(32'h800003B7, 64'h100C);
    check("lui_class", {60'd0, a_class}, 64'd5);
    check("lui_imm",   a_imm, 64'hFFFF_FFFF_8000_0000);
    check("lui_rd",    {59'd0, a_rd}, 64'd7);
    check("b_lui_imm", {32'd0, b_imm}, 64'h8000_0000);

    // jal x1,+16 at 0x2000
    push1(32'h010000EF, 64'h2000);
    check("jal_class",  {60'd0, a_class}, 64'd7);
    check("jal_imm",    a_imm, 64'd16);
    check("jal_target", a_target, 64'h2010);
    check("jal_we",     {63'd0, a_we_rd}, 64'd1);

    // ld x5,8(x6): RV64 only
    push1(32'h00833283, 64'h2004);
    check("ld_class",   {60'd0, a_class}, 64'd2);
    check("ld_imm",     a_imm, 64'd8);
    check("b_ld_ill",   {63'd0, b_illegal}, 64'd1);

    // ecall, then unknown opcode
    push1(32'h00000073, 64'h2008);
    check("ecall_class", {60'd0, a_class}, 64'd11);
    check("ecall_ill",   {63'd0, a_illegal}, 64'd0);
    push1(32'h0000007F, 64'h200C);
    check("unk_class", {60'd0, a_class}, 64'd15);
    check("unk_ill",   {63'd0, a_illegal}, 64'd1);
    check("unk_halt",  {63'd0, a_halt}, 64'd0);

    // Fresh start so the handshake counter begins at zero
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Backpressure: three back-to-back pushes into a stalled buffer
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 64'h100;
    @(negedge clk);
    in_instr = 32'h00200113; in_pc = 64'h104;
    @(negedge clk);
    check("full_in_ready", {63'd0, a_in_ready}, 64'd0);
    check("full_head_pc",  a_pc, 64'h100);
    in_instr = 32'h00300193; in_pc = 64'h108;
    @(negedge clk);
    check("held_in_ready", {63'd0, a_in_ready}, 64'd0);
    check("held_head_rd",  {59'd0, a_rd}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    check("drain1_rd",       {59'd0, a_rd}, 64'd2);
    check("drain1_in_ready", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk);
    check("drain2_rd", {59'd0, a_rd}, 64'd3);
    check("drain2_pc", a_pc, 64'h108);
    in_valid = 1'b0;
    @(negedge clk);
    check("empty_valid", {63'd0, a_out_valid}, 64'd0);
    check("empty_hold_rd", {59'd0, a_rd}, 64'd3);
    check("count3",   {32'd0, a_count}, 64'd3);
    check("b_count3", {32'd0, b_count}, 64'd3);

    // Flush with two records buffered
    out_ready = 1'b0;
    push1(32'h00100093, 64'h200);
    push1(32'h00200113, 64'h204);
    check("pre_flush_valid", {63'd0, a_out_valid}, 64'd1);
    flush = 1'b1; out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 64'h208;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid",    {63'd0, a_out_valid}, 64'd0);
    check("flush_count",    {32'd0, a_count}, 64'd3);
    check("flush_in_ready", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk);
    check("post_flush_valid", {63'd0, a_out_valid}, 64'd0);

    // Reset in the middle of a burst clears the outputs asynchronously
    out_ready = 1'b0;
    push1(32'h800003B7, 64'h3000);
    push1(32'h010000EF, 64'h3004);
    check("burst_rd", {59'd0, a_rd}, 64'd7);
    reset = 1'b1;
    #1;
    check("mrst_valid", {63'd0, a_out_valid}, 64'd0);
    check("mrst_pc",    a_pc, 64'd0);
    check("mrst_rd",    {59'd0, a_rd}, 64'd0);
    check("mrst_imm",   a_imm, 64'd0);
    check("mrst_count", {32'd0, a_count}, 64'd0);
    check("mrst_in_ready", {63'd0, a_in_ready}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;

    // All-zero word is the halt request
    push1(32'h00000000, 64'h4000);
    check("halt_valid", {63'd0, a_out_valid}, 64'd1);
    check("halt_halt",  {63'd0, a_halt}, 64'd1);
    check("halt_ill",   {63'd0, a_illegal}, 64'd0);
    check("halt_class", {60'd0, a_class}, 64'd15);
    check("halt_we",    {63'd0, a_we_rd}, 64'd0);
    check("b_halt",     {63'd0, b_halt}, 64'd1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
